datapath_param: RTL and testbench
=================================

# datapath_param

Parametrised successor to the 16-bit RISC datapath: register file, A/B operand registers, shifter, ALU, result register C and Z/N/V status register, generalised in data width, register count and PC width. Adds a multi-cycle unsigned shift-add multiply mode with a start/busy/done handshake. Driven cycle-by-cycle by the CPU controller FSM; C feeds `datapath_out`.

## Interface
- `WIDTH`, 16: data width of registers, operands, ALU and C.
- `NREGS`, 8: register-file depth; power of two, at least 2. `AW = $clog2(NREGS)`.
- `PCW`, 9: PC width; must be at most `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `vsel`  in  2  write-back select: 00 `mdata`, 01 `sximm8`, 10 zero-extended `PC`, 11 C.
- `mdata`, `sximm8`, `sximm5`  in  WIDTH each  write-back and immediate operands.
- `PC`  in  PCW  program counter.
- `writenum`, `readnum`  in  AW each  register-file write and read indices.
- `write`  in  1  register-file write enable.
- `loada`, `loadb`, `loadc`, `loads`  in  1 each  load enables for A, B, C and status.
- `shift`  in  2  shifter mode for B.
- `asel`  in  1  1 selects zero for Ain; 0 selects A.
- `bsel`  in  1  1 selects `sximm5` for Bin; 0 selects shifter output.
- `ALUop`  in  2  ALU operation.
- `mul_start`  in  1  one-cycle request to start a multiply.
- `mul_busy`  out  1  multiplier running.
- `mul_done`  out  1  one-cycle pulse; C and status hold the product.
- `Z_out`, `N_out`, `V_out`  out  1 each  registered status flags.
- `datapath_out`  out  WIDTH  equals C.

## Operation
- Register file: synchronous write of the write-back mux on `clk` when `write` is high. Read of `readnum` is combinational; read-during-write returns the old value.
- A and B load the register-file read data on `clk` when `loada` / `loadb` is high.
- Shifter on B:
  - 00: pass.
  - 01: left by 1, zero fill.
  - 10: logical right by 1.
  - 11: arithmetic right by 1, MSB replicated.
- ALU on (Ain, Bin), truncated to WIDTH:
  - 00: Ain+Bin.
  - 01: Ain−Bin.
  - 10: Ain&Bin.
  - 11: ~Bin.
- Flags:
  - Z is set when the result is 0.
  - N is the result MSB.
  - V is two's-complement signed overflow for add/sub, and 0 for AND/MVN.
- C loads the ALU result when `loadc` is high. Status loads {Z,V,N} when `loads` is high.
- Multiply, states IDLE → RUN → IDLE:
  - `mul_start` is accepted only in IDLE. It captures the current Ain and Bin as unsigned operands.
  - RUN performs one shift-add step per cycle for WIDTH cycles into a 2·WIDTH accumulator.
  - On completion, C receives the low WIDTH bits of the product.
  - Status receives: Z = (low half == 0), N = low-half MSB, V = (high half != 0), i.e. unsigned overflow.
- `mul_start` while `mul_busy` is ignored; there is no queueing.
- In the completion cycle, the multiplier write to C and status overrides `loadc` and `loads`.
- During RUN, the ALU path, A, B, the register file, and `loadc`/`loads` (outside the completion cycle) operate normally. Operands are already captured.

## Timing
- Reset, asynchronous: all registers, A, B, C and status are 0. Multiplier is in IDLE; `mul_busy` = 0 and `mul_done` = 0. `datapath_out` = 0.
- Reset asserted during RUN aborts the multiply. No `mul_done` is produced.
- Latency:
  - Register write at edge k is readable after edge k.
  - Read → A/B: 1 edge.
  - A/B → C/status: 1 edge.
- Multiply, start sampled at edge 0:
  - `mul_busy` is high after edge 0 through edge WIDTH.
  - C and status update at edge WIDTH.
  - `mul_busy` falls and `mul_done` is high for exactly the one cycle after edge WIDTH.
  - A new `mul_start` is accepted in that `mul_done` cycle.
- `PC` is zero-extended to WIDTH on write-back.

## Structure
- `datapath_pkg` holds:
  - enums `alu_op_t` (ADD, SUB, AND, MVN), `shift_t` (NOP, LSL, LSR, ASR), `vsel_t` (MDATA, IMM8, PC, C);
  - the multiplier state enum `mul_state_t` (IDLE, RUN).
- Sub-module `seq_multiplier` (parameter WIDTH):
  - inputs: `clk`, `reset`, `start`, `a`, `b`;
  - outputs: `busy`, `done`, `product[2*WIDTH-1:0]`.
- Regfile, shifter and ALU are parametrised versions of the existing blocks.

## Test plan
- Reset mid-operation with R3 = 0x1234, C = 0x00FF → all outputs 0, R3 reads 0, `mul_busy` = 0.
- R0 = 7, R1 = 0xFFFE, ALU SUB A=R0 B=R1, `loads` → C = 0x0009, Z=0, N=0, V=0. Then R0 = 0x7FFF, R1 = 1, ADD → C = 0x8000, N=1, V=1.
- Shifter with B = 0x8001 → LSL 0x0002, LSR 0x4000, ASR 0xC000, all with asel=1 and ADD.
- Multiply 0x0012 × 0x0034, WIDTH = 16 → `mul_done` exactly 16 cycles after start, C = 0x03A8, V=0. Repeat with 0x0100 × 0x0100 → C = 0, Z=1, V=1. Second `mul_start` sent while busy → ignored.
- Same cycle as completion with `loadc=1`, ALU producing 0x5555 → C holds the product, not 0x5555.
- WIDTH=8, NREGS=16, PCW=6: write R15 with `vsel`=PC and PC = 0x2A → R15 = 0x2A; 8-bit multiply 0x0F × 0x11 → C = 0xFF after 8 cycles.

Source files
------------

// File: rtl/datapath_param_pkg.sv
// Shared types for the parametrised datapath: ALU/shift/write-back encodings
// and the multiplier state encoding.
package datapath_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    MVN = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    NOP = 2'b00,
    LSL = 2'b01,
    LSR = 2'b10,
    ASR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    MDATA = 2'b00,
    IMM8  = 2'b01,
    PC    = 2'b10,
    C     = 2'b11
  } vsel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_t;

endpackage

// File: rtl/datapath_param_if.sv
// Controller <-> datapath bundle. The controller is the master; the datapath
// is the slave.
interface datapath_param_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned PCW   = 9
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [1:0]       vsel;
  logic [WIDTH-1:0] mdata;
  logic [WIDTH-1:0] sximm8;
  logic [WIDTH-1:0] sximm5;
  logic [PCW-1:0]   PC;
  logic [AW-1:0]    writenum;
  logic [AW-1:0]    readnum;
  logic             write;
  logic             loada;
  logic             loadb;
  logic             loadc;
  logic             loads;
  logic [1:0]       shift;
  logic             asel;
  logic             bsel;
  logic [1:0]       ALUop;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic             Z_out;
  logic             N_out;
  logic             V_out;
  logic [WIDTH-1:0] datapath_out;

  modport master (
    output vsel, mdata, sximm8, sximm5, PC, writenum, readnum, write,
           loada, loadb, loadc, loads, shift, asel, bsel, ALUop, mul_start,
    input  mul_busy, mul_done, Z_out, N_out, V_out, datapath_out
  );

  modport slave (
    input  vsel, mdata, sximm8, sximm5, PC, writenum, readnum, write,
           loada, loadb, loadc, loads, shift, asel, bsel, ALUop, mul_start,
    output mul_busy, mul_done, Z_out, N_out, V_out, datapath_out
  );
endinterface

// File: rtl/datapath_param_seq_multiplier.sv
// Unsigned shift-add multiplier, one partial product per cycle. The first
// partial product is folded into the start edge so the product is complete
// one cycle before done, letting the parent capture it on the done edge.
module seq_multiplier
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic ST_IDLE = IDLE;
  localparam logic ST_RUN  = RUN;

  logic               state_q;
  logic               done_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  assign busy    = (state_q == ST_RUN);
  // High in the final RUN cycle: product is complete, done rises next edge.
  assign last    = busy && (cnt_q == CW'(WIDTH));
  assign done    = done_q;
  assign product = acc_q;

  // Capture operands on start, then accumulate one multiplier bit per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start) begin
          state_q  <= ST_RUN;
          acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
          mcand_q  <= {{WIDTH{1'b0}}, a} << 1;
          mplier_q <= b >> 1;
          cnt_q    <= CW'(1);
        end
      end else if (last) begin
        state_q <= ST_IDLE;
        done_q  <= 1'b1;
      end else begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/datapath_param.sv
// Parametrised RISC datapath: register file, A/B, shifter, ALU, C and
// Z/N/V status, plus a sequential multiply that writes C/status on completion.
module datapath_param
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned PCW   = 9
) (
  input logic             clk,
  input logic             reset,
  datapath_param_if.slave bus
);
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   wb_data;
  logic [WIDTH-1:0]   a_q, b_q, sh_out, ain, bin, alu_out, c_q;
  logic               alu_v;
  logic               z_q, n_q, v_q;
  logic               mul_busy, mul_done, mul_last;
  logic [2*WIDTH-1:0] mul_product;

  // Write-back source select.
  always_comb begin
    wb_data = bus.mdata;
    unique case (vsel_t'(bus.vsel))
      MDATA:   wb_data = bus.mdata;
      IMM8:    wb_data = bus.sximm8;
      PC:      wb_data = WIDTH'(bus.PC);
      C:       wb_data = c_q;
      default: wb_data = bus.mdata;
    endcase
  end

  // Register file write; reads are combinational and see the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (bus.write) begin
      regs_q[bus.writenum] <= wb_data;
    end
  end

  // Operand registers A and B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (bus.loada) a_q <= regs_q[bus.readnum];
      if (bus.loadb) b_q <= regs_q[bus.readnum];
    end
  end

  // Shifter on B.
  always_comb begin
    sh_out = b_q;
    unique case (shift_t'(bus.shift))
      NOP:     sh_out = b_q;
      LSL:     sh_out = b_q << 1;
      LSR:     sh_out = b_q >> 1;
      ASR:     sh_out = $signed(b_q) >>> 1;
      default: sh_out = b_q;
    endcase
  end

  assign ain = bus.asel ? '0 : a_q;
  assign bin = bus.bsel ? bus.sximm5 : sh_out;

  // ALU with signed overflow for add/sub.
  always_comb begin
    alu_out = '0;
    alu_v   = 1'b0;
    unique case (alu_op_t'(bus.ALUop))
      ADD: begin
        alu_out = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      SUB: begin
        alu_out = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      AND:     alu_out = ain & bin;
      MVN:     alu_out = ~bin;
      default: alu_out = '0;
    endcase
  end

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.mul_start),
    .a      (ain),
    .b      (bin),
    .busy   (mul_busy),
    .done   (mul_done),
    .last   (mul_last),
    .product(mul_product)
  );

  // C and status; multiply completion takes priority over loadc/loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else if (mul_last) begin
      c_q <= mul_product[WIDTH-1:0];
      z_q <= (mul_product[WIDTH-1:0] == '0);
      n_q <= mul_product[WIDTH-1];
      v_q <= |mul_product[2*WIDTH-1:WIDTH];
    end else begin
      if (bus.loadc) c_q <= alu_out;
      if (bus.loads) begin
        z_q <= (alu_out == '0);
        n_q <= alu_out[WIDTH-1];
        v_q <= alu_v;
      end
    end
  end

  assign bus.datapath_out = c_q;
  assign bus.Z_out        = z_q;
  assign bus.N_out        = n_q;
  assign bus.V_out        = v_q;
  assign bus.mul_busy     = mul_busy;
  assign bus.mul_done     = mul_done;

endmodule

// File: tb/tb_datapath_param.sv
// Directed bench for datapath_param: a 16-bit default instance and an
// 8-bit / 16-register / 6-bit-PC instance sharing clock and reset.
module tb_datapath_param;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  datapath_param_if #(.WIDTH(16), .NREGS(8),  .PCW(9)) bus16 ();
  datapath_param_if #(.WIDTH(8),  .NREGS(16), .PCW(6)) bus8 ();

  datapath_param #(.WIDTH(16), .NREGS(8), .PCW(9)) dut16 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus16)
  );

  datapath_param #(.WIDTH(8), .NREGS(16), .PCW(6)) dut8 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle16();
    bus16.vsel = 2'd0; bus16.mdata = '0; bus16.sximm8 = '0; bus16.sximm5 = '0;
    bus16.PC = '0; bus16.writenum = '0; bus16.readnum = '0; bus16.write = 1'b0;
    bus16.loada = 1'b0; bus16.loadb = 1'b0; bus16.loadc = 1'b0; bus16.loads = 1'b0;
    bus16.shift = 2'd0; bus16.asel = 1'b0; bus16.bsel = 1'b0; bus16.ALUop = 2'd0;
    bus16.mul_start = 1'b0;
  endtask

  task automatic idle8();
    bus8.vsel = 2'd0; bus8.mdata = '0; bus8.sximm8 = '0; bus8.sximm5 = '0;
    bus8.PC = '0; bus8.writenum = '0; bus8.readnum = '0; bus8.write = 1'b0;
    bus8.loada = 1'b0; bus8.loadb = 1'b0; bus8.loadc = 1'b0; bus8.loads = 1'b0;
    bus8.shift = 2'd0; bus8.asel = 1'b0; bus8.bsel = 1'b0; bus8.ALUop = 2'd0;
    bus8.mul_start = 1'b0;
  endtask

  task automatic wr16(input logic [2:0] idx, input logic [15:0] val);
    bus16.vsel = 2'd0; bus16.mdata = val; bus16.writenum = idx; bus16.write = 1'b1;
    tick();
    bus16.write = 1'b0;
  endtask

  task automatic ld16(input logic [2:0] ra, input logic [2:0] rb);
    bus16.readnum = ra; bus16.loada = 1'b1;
    tick();
    bus16.loada = 1'b0; bus16.readnum = rb; bus16.loadb = 1'b1;
    tick();
    bus16.loadb = 1'b0;
  endtask

  task automatic alu16(input logic [1:0] op, input logic [1:0] sh, input logic as,
                       input logic bs);
    bus16.ALUop = op; bus16.shift = sh; bus16.asel = as; bus16.bsel = bs;
    bus16.loadc = 1'b1; bus16.loads = 1'b1;
    tick();
    bus16.loadc = 1'b0; bus16.loads = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    wr16(3'd3, 16'h1234);
    wr16(3'd2, 16'h00FF);
    ld16(3'd2, 3'd2);
    alu16(2'd0, 2'd0, 1'b1, 1'b0);
    n_cmp++; if (bus16.datapath_out !== 16'h00FF) begin n_bad++;
      $display("FAIL pre_reset_c: got %h want 00ff", bus16.datapath_out); end
    bus16.mul_start = 1'b1;
    tick();
    bus16.mul_start = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus16.mul_busy !== 1'b1) begin n_bad++;
      $display("FAIL pre_reset_busy: got %b want 1", bus16.mul_busy); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus16.datapath_out !== 16'h0000) begin n_bad++;
      $display("FAIL reset_c: got %h want 0000", bus16.datapath_out); end
    n_cmp++; if ({bus16.Z_out, bus16.N_out, bus16.V_out} !== 3'b000) begin n_bad++;
      $display("FAIL reset_znv: got %b want 000", {bus16.Z_out, bus16.N_out, bus16.V_out}); end
    n_cmp++; if ({bus16.mul_busy, bus16.mul_done} !== 2'b00) begin n_bad++;
      $display("FAIL reset_mul: got %b want 00", {bus16.mul_busy, bus16.mul_done}); end
    #2 reset = 1'b0;
    ld16(3'd3, 3'd3);
    alu16(2'd3, 2'd0, 1'b0, 1'b0);
    n_cmp++; if (bus16.datapath_out !== 16'hFFFF) begin n_bad++;
      $display("FAIL reset_r3: got %h want ffff", bus16.datapath_out); end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus16.mul_done || bus16.mul_busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++;
      $display("FAIL reset_abort: got busy/done activity %b want 0", seen); end
  endtask

  task automatic test_alu();
    wr16(3'd0, 16'h0007);
    wr16(3'd1, 16'hFFFE);
    ld16(3'd0, 3'd1);
    alu16(2'd1, 2'd0, 1'b0, 1'b0);
    n_cmp++; if (bus16.datapath_out !== 16'h0009) begin n_bad++;
      $display("FAIL sub_c: got %h want 0009", bus16.datapath_out); end
    n_cmp++; if ({bus16.Z_out, bus16.N_out, bus16.V_out} !== 3'b000) begin n_bad++;
      $display("FAIL sub_znv: got %b want 000", {bus16.Z_out, bus16.N_out, bus16.V_out}); end
    wr16(3'd0, 16'h7FFF);
    wr16(3'd1, 16'h0001);
    ld16(3'd0, 3'd1);
    alu16(2'd0, 2'd0, 1'b0, 1'b0);
    n_cmp++; if (bus16.datapath_out !== 16'h8000) begin n_bad++;
      $display("FAIL add_ovf_c: got %h want 8000", bus16.datapath_out); end
    n_cmp++; if ({bus16.Z_out, bus16.N_out, bus16.V_out} !== 3'b011) begin n_bad++;
      $display("FAIL add_ovf_znv: got %b want 011", {bus16.Z_out, bus16.N_out, bus16.V_out}); end
    alu16(2'd2, 2'd0, 1'b0, 1'b0);
    n_cmp++; if ({bus16.datapath_out, bus16.V_out} !== {16'h0001, 1'b0}) begin n_bad++;
      $display("FAIL and: got %h/%b want 0001/0", bus16.datapath_out, bus16.V_out); end
    alu16(2'd3, 2'd0, 1'b0, 1'b0);
    n_cmp++; if ({bus16.datapath_out, bus16.N_out} !== {16'hFFFE, 1'b1}) begin n_bad++;
      $display("FAIL mvn: got %h/%b want fffe/1", bus16.datapath_out, bus16.N_out); end
    ld16(3'd1, 3'd1);
    alu16(2'd1, 2'd0, 1'b0, 1'b0);
    n_cmp++; if ({bus16.datapath_out, bus16.Z_out} !== {16'h0000, 1'b1}) begin n_bad++;
      $display("FAIL sub_zero: got %h/%b want 0000/1", bus16.datapath_out, bus16.Z_out); end
    wr16(3'd2, 16'h8000);
    ld16(3'd2, 3'd1);
    alu16(2'd1, 2'd0, 1'b0, 1'b0);
    n_cmp++; if ({bus16.datapath_out, bus16.N_out, bus16.V_out} !== {16'h7FFF, 2'b01}) begin
      n_bad++;
      $display("FAIL sub_ovf: got %h/%b%b want 7fff/01", bus16.datapath_out, bus16.N_out,
               bus16.V_out); end
  endtask

  task automatic test_writeback();
    bus16.vsel = 2'd1; bus16.sximm8 = 16'hFFF0; bus16.writenum = 3'd7; bus16.write = 1'b1;
    tick();
    bus16.write = 1'b0;
    ld16(3'd7, 3'd7);
    alu16(2'd0, 2'd0, 1'b1, 1'b0);
    n_cmp++; if (bus16.datapath_out !== 16'hFFF0) begin n_bad++;
      $display("FAIL wb_imm8: got %h want fff0", bus16.datapath_out); end
    bus16.vsel = 2'd3; bus16.writenum = 3'd4; bus16.write = 1'b1;
    tick();
    bus16.write = 1'b0;
    ld16(3'd4, 3'd4);
    alu16(2'd3, 2'd0, 1'b0, 1'b0);
    n_cmp++; if (bus16.datapath_out !== 16'h000F) begin n_bad++;
      $display("FAIL wb_c: got %h want 000f", bus16.datapath_out); end
    bus16.vsel = 2'd2; bus16.PC = 9'h1A5; bus16.writenum = 3'd5; bus16.write = 1'b1;
    tick();
    bus16.write = 1'b0;
    ld16(3'd5, 3'd5);
    alu16(2'd0, 2'd0, 1'b1, 1'b0);
    n_cmp++; if (bus16.datapath_out !== 16'h01A5) begin n_bad++;
      $display("FAIL wb_pc: got %h want 01a5", bus16.datapath_out); end
    // Write R5 and load B from R5 on the same edge: B must get the old value.
    bus16.vsel = 2'd0; bus16.mdata = 16'h0042; bus16.writenum = 3'd5; bus16.write = 1'b1;
    bus16.readnum = 3'd5; bus16.loadb = 1'b1;
    tick();
    bus16.write = 1'b0; bus16.loadb = 1'b0;
    alu16(2'd0, 2'd0, 1'b1, 1'b0);
    n_cmp++; if (bus16.datapath_out !== 16'h01A5) begin n_bad++;
      $display("FAIL rdw_old: got %h want 01a5", bus16.datapath_out); end
    ld16(3'd5, 3'd5);
    alu16(2'd0, 2'd0, 1'b1, 1'b0);
    n_cmp++; if (bus16.datapath_out !== 16'h0042) begin n_bad++;
      $display("FAIL rdw_new: got %h want 0042", bus16.datapath_out); end
  endtask

  task automatic test_shifter();
    logic [15:0] exp_sh [4];
    exp_sh = '{16'h8001, 16'h0002, 16'h4000, 16'hC000};
    wr16(3'd2, 16'h8001);
    ld16(3'd2, 3'd2);
    for (int sh = 0; sh < 4; sh++) begin
      alu16(2'd0, 2'(sh), 1'b1, 1'b0);
      n_cmp++; if (bus16.datapath_out !== exp_sh[sh]) begin n_bad++;
        $display("FAIL shift_%0d: got %h want %h", sh, bus16.datapath_out, exp_sh[sh]); end
    end
    bus16.shift = 2'd0;
  endtask

  task automatic test_multiply();
    int done_at;
    bit busy_ok;
    wr16(3'd4, 16'h0012);
    wr16(3'd5, 16'h0034);
    wr16(3'd6, 16'h0100);
    ld16(3'd4, 3'd5);
    bus16.asel = 1'b0; bus16.bsel = 1'b0; bus16.shift = 2'd0;
    bus16.mul_start = 1'b1;
    tick();
    bus16.mul_start = 1'b0;
    n_cmp++; if (bus16.mul_busy !== 1'b1) begin n_bad++;
      $display("FAIL mul_busy_rise: got %b want 1", bus16.mul_busy); end
    done_at = 0;
    busy_ok = 1'b1;
    // Reload A/B mid-run and fire an ignored start while busy.
    for (int k = 1; k <= 40; k++) begin
      bus16.mul_start = (k == 5);
      bus16.loada = (k == 2);
      bus16.loadb = (k == 3);
      bus16.readnum = 3'd6;
      tick();
      if (bus16.mul_done) begin done_at = k; break; end
      if (!bus16.mul_busy) busy_ok = 1'b0;
    end
    bus16.mul_start = 1'b0; bus16.loada = 1'b0; bus16.loadb = 1'b0;
    n_cmp++; if (done_at !== 16) begin n_bad++;
      $display("FAIL mul1_latency: got %0d want 16", done_at); end
    n_cmp++; if (busy_ok !== 1'b1) begin n_bad++;
      $display("FAIL mul1_busy_hold: got %b want 1", busy_ok); end
    n_cmp++; if (bus16.datapath_out !== 16'h03A8) begin n_bad++;
      $display("FAIL mul1_c: got %h want 03a8", bus16.datapath_out); end
    n_cmp++; if ({bus16.Z_out, bus16.N_out, bus16.V_out, bus16.mul_busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mul1_flags: got %b want 0000",
               {bus16.Z_out, bus16.N_out, bus16.V_out, bus16.mul_busy}); end
    // Start again in the done cycle with A = B = 0x0100.
    bus16.mul_start = 1'b1;
    tick();
    bus16.mul_start = 1'b0;
    n_cmp++; if ({bus16.mul_done, bus16.mul_busy} !== 2'b01) begin n_bad++;
      $display("FAIL mul2_accept: got done/busy %b want 01", {bus16.mul_done, bus16.mul_busy}); end
    done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus16.mul_done) begin done_at = k; break; end
    end
    n_cmp++; if (done_at !== 16) begin n_bad++;
      $display("FAIL mul2_latency: got %0d want 16", done_at); end
    n_cmp++; if ({bus16.datapath_out, bus16.Z_out, bus16.N_out, bus16.V_out} !==
                 {16'h0000, 3'b101}) begin n_bad++;
      $display("FAIL mul2_result: got %h/%b want 0000/101", bus16.datapath_out,
               {bus16.Z_out, bus16.N_out, bus16.V_out}); end
  endtask

  task automatic test_override();
    int done_at;
    // A = B = 0x0100 from the previous test.
    bus16.asel = 1'b0; bus16.bsel = 1'b0; bus16.shift = 2'd0;
    bus16.mul_start = 1'b1;
    tick();
    bus16.mul_start = 1'b0;
    bus16.asel = 1'b1; bus16.bsel = 1'b1; bus16.sximm5 = 16'h5555; bus16.ALUop = 2'd0;
    bus16.loadc = 1'b1; bus16.loads = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++; if (bus16.datapath_out !== 16'h5555) begin n_bad++;
      $display("FAIL ovr_midrun_c: got %h want 5555", bus16.datapath_out); end
    done_at = 0;
    for (int k = 4; k <= 40; k++) begin
      tick();
      if (bus16.mul_done) begin done_at = k; break; end
    end
    n_cmp++; if (done_at !== 16) begin n_bad++;
      $display("FAIL ovr_latency: got %0d want 16", done_at); end
    n_cmp++; if ({bus16.datapath_out, bus16.Z_out, bus16.V_out} !== {16'h0000, 2'b11}) begin
      n_bad++;
      $display("FAIL ovr_result: got %h/%b%b want 0000/11", bus16.datapath_out, bus16.Z_out,
               bus16.V_out); end
    bus16.loadc = 1'b0; bus16.loads = 1'b0; bus16.asel = 1'b0; bus16.bsel = 1'b0;
  endtask

  task automatic test_param8();
    int done_at;
    bus8.vsel = 2'd2; bus8.PC = 6'h2A; bus8.writenum = 4'd15; bus8.write = 1'b1;
    tick();
    bus8.write = 1'b0;
    bus8.readnum = 4'd15; bus8.loadb = 1'b1;
    tick();
    bus8.loadb = 1'b0;
    bus8.asel = 1'b1; bus8.bsel = 1'b0; bus8.ALUop = 2'd0; bus8.loadc = 1'b1; bus8.loads = 1'b1;
    tick();
    bus8.loadc = 1'b0; bus8.loads = 1'b0;
    n_cmp++; if (bus8.datapath_out !== 8'h2A) begin n_bad++;
      $display("FAIL w8_pc_r15: got %h want 2a", bus8.datapath_out); end
    bus8.vsel = 2'd0; bus8.mdata = 8'h0F; bus8.writenum = 4'd0; bus8.write = 1'b1;
    tick();
    bus8.mdata = 8'h11; bus8.writenum = 4'd1;
    tick();
    bus8.write = 1'b0; bus8.readnum = 4'd0; bus8.loada = 1'b1;
    tick();
    bus8.loada = 1'b0; bus8.readnum = 4'd1; bus8.loadb = 1'b1;
    tick();
    bus8.loadb = 1'b0; bus8.asel = 1'b0; bus8.bsel = 1'b0; bus8.mul_start = 1'b1;
    tick();
    bus8.mul_start = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus8.mul_done) begin done_at = k; break; end
    end
    n_cmp++; if (done_at !== 8) begin n_bad++;
      $display("FAIL w8_mul_latency: got %0d want 8", done_at); end
    n_cmp++; if ({bus8.datapath_out, bus8.Z_out, bus8.N_out, bus8.V_out} !== {8'hFF, 3'b010})
    begin n_bad++;
      $display("FAIL w8_mul_result: got %h/%b want ff/010", bus8.datapath_out,
               {bus8.Z_out, bus8.N_out, bus8.V_out}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle16();
    idle8();
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_alu();
    test_writeback();
    test_shifter();
    test_multiply();
    test_override();
    test_param8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
